risc_cpu_mp: RTL and testbench

//  Parametrised multi-cycle accumulator CPU, 8-op ISA (HLT SKZ ADD AND XOR LDA STO JMP).

---
 rtl/risc_cpu_mp_if.sv | 23 ++
 rtl/risc_cpu_mp.sv | 114 +++++++++++
 tb/tb_risc_cpu_mp.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_cpu_mp_if.sv
// Single-port memory bus between the accumulator CPU and its external memory.
// One transfer completes on each clk edge where (mem_rd | mem_wr) & mem_ready.
interface risc_cpu_mp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/risc_cpu_mp.sv
// Multi-cycle accumulator CPU (HLT SKZ ADD AND XOR LDA STO JMP) with an
// external wait-state memory bus and a resume-from-halt input.
module risc_cpu_mp #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    risc_cpu_mp_if.master     bus,
    input  logic              resume,
    output logic              halt,
    output logic [DATA_W-1:0] acc,
    output logic              is_zero
);

    if (DATA_W < ADDR_W + 3) begin : g_param_check
        $error("risc_cpu_mp: DATA_W must be at least ADDR_W+3");
    end

    typedef enum logic [2:0] {FETCH, DECODE, READ, WRITE, HALT} state_t;
    typedef enum logic [2:0] {
        OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
    } opcode_t;

    state_t            state, state_nx;
    logic              live;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [DATA_W-1:0] ir, ir_nx, acc_nx;
    opcode_t           op;
    logic [ADDR_W-1:0] operand;

    assign op      = opcode_t'(ir[DATA_W-1 -: 3]);
    assign operand = ir[ADDR_W-1:0];
    assign is_zero = (acc == '0);

    // live keeps the first fetch request off the bus until the first edge after reset.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            live  <= 1'b0;
            pc    <= RESET_PC;
            ir    <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            pc    <= pc_nx;
            ir    <= ir_nx;
            acc   <= acc_nx;
        end
    end

    // Bus outputs depend on state/ir/pc only, never on mem_ready.
    always_comb begin
        bus.mem_rd    = (state == FETCH && live) || (state == READ);
        bus.mem_wr    = (state == WRITE);
        bus.mem_addr  = (state == READ || state == WRITE) ? operand : pc;
        bus.mem_wdata = (state == WRITE) ? acc : '0;
        halt          = (state == HALT);
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        acc_nx   = acc;
        case (state)
            FETCH: begin
                if (bus.mem_rd && bus.mem_ready) begin
                    ir_nx    = bus.mem_rdata;
                    pc_nx    = pc + 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                case (op)
                    OP_HLT: state_nx = HALT;
                    OP_SKZ: begin
                        if (acc == '0) pc_nx = pc + 1'b1;
                        state_nx = FETCH;
                    end
                    OP_JMP: begin
                        pc_nx    = operand;
                        state_nx = FETCH;
                    end
                    OP_STO:  state_nx = WRITE;
                    default: state_nx = READ;
                endcase
            end
            READ: begin
                if (bus.mem_ready) begin
                    case (op)
                        OP_ADD:  acc_nx = acc + bus.mem_rdata;
                        OP_AND:  acc_nx = acc & bus.mem_rdata;
                        OP_XOR:  acc_nx = acc ^ bus.mem_rdata;
                        default: acc_nx = bus.mem_rdata;
                    endcase
                    state_nx = FETCH;
                end
            end
            WRITE: begin
                if (bus.mem_ready) state_nx = FETCH;
            end
            HALT: begin
                if (resume) state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

endmodule

// File: tb/tb_risc_cpu_mp.sv
// Directed bench for risc_cpu_mp: an 8/5 instance with a wait-state memory model
// and a 16/10 instance for the wide-parameter arithmetic check.
module tb_risc_cpu_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic resume = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- 8-bit instance and its memory model ----------------
    risc_cpu_mp_if #(.DATA_W(8), .ADDR_W(5)) bus ();
    logic       halt;
    logic [7:0] acc;
    logic       is_zero;

    risc_cpu_mp #(.DATA_W(8), .ADDR_W(5), .RESET_PC(5'd0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .resume(resume), .halt(halt), .acc(acc), .is_zero(is_zero)
    );

    logic [7:0] mem [0:31];
    logic       ready_en = 1'b1;
    int         wait_cfg = 0;
    int         wait_left = 0;
    logic       cap_req = 1'b0;
    logic       cap_rdy = 1'b0;
    logic       prev_wait = 1'b0;
    logic [4:0] prev_addr = '0;
    logic       prev_rd = 1'b0;
    int         stab_err = 0;

    logic       log_wr   [0:63];
    logic [4:0] log_addr [0:63];
    logic [7:0] log_data [0:63];
    int         log_n = 0;

    // Wait states apply only to the program area (addresses 0..3), i.e. to fetches.
    assign bus.mem_rdata = mem[bus.mem_addr];
    assign bus.mem_ready = ready_en && !((bus.mem_addr < 5'd4) && (wait_left != 0));

    always @(negedge clk) begin
        cap_req = rst_n && (bus.mem_rd || bus.mem_wr);
        cap_rdy = bus.mem_ready;
        if (cap_req && cap_rdy && log_n < 64) begin
            log_wr[log_n]   = bus.mem_wr;
            log_addr[log_n] = bus.mem_addr;
            log_data[log_n] = bus.mem_wr ? bus.mem_wdata : bus.mem_rdata;
            log_n++;
            if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
        end
        if (cap_req && !cap_rdy) begin
            if (prev_wait && (bus.mem_addr != prev_addr || bus.mem_rd != prev_rd)) stab_err++;
            prev_wait = 1'b1;
            prev_addr = bus.mem_addr;
            prev_rd   = bus.mem_rd;
        end else begin
            prev_wait = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n)       wait_left <= wait_cfg;
        else if (cap_req) wait_left <= cap_rdy ? wait_cfg : wait_left - 1;
    end

    // ---------------- 16-bit instance ----------------
    risc_cpu_mp_if #(.DATA_W(16), .ADDR_W(10)) bus2 ();
    logic        halt2;
    logic [15:0] acc2;
    logic        is_zero2;
    logic [15:0] mem2 [0:1023];

    assign bus2.mem_rdata = mem2[bus2.mem_addr];
    assign bus2.mem_ready = 1'b1;

    risc_cpu_mp #(.DATA_W(16), .ADDR_W(10), .RESET_PC(10'd0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .resume(1'b0), .halt(halt2), .acc(acc2), .is_zero(is_zero2)
    );

    // ---------------- expected T2 memory trace ----------------
    logic       exp_wr   [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] exp_addr [0:6] = '{5'd0, 5'd10, 5'd1, 5'd11, 5'd2, 5'd12, 5'd3};
    logic [7:0] exp_data [0:6] = '{8'hAA, 8'h7F, 8'h4B, 8'h83, 8'hCC, 8'h02, 8'h00};

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        log_n    = 0;
        stab_err = 0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_alu_prog();
        mem[0]  = 8'hAA;  // LDA 10
        mem[1]  = 8'h4B;  // ADD 11
        mem[2]  = 8'hCC;  // STO 12
        mem[3]  = 8'h00;  // HLT
        mem[10] = 8'h7F;
        mem[11] = 8'h83;
    endtask

    // Cycles are counted from the first cycle with the fetch request on the bus.
    task automatic run_to_halt(output int cyc);
        int k = 0;
        while (!bus.mem_rd && k < 5) begin @(negedge clk); k++; end
        cyc = 0;
        while (!halt && cyc < 300) begin @(negedge clk); cyc++; end
    endtask

    task automatic test_reset();
        int k;
        ready_en = 1'b1;
        wait_cfg = 0;
        hold_reset();
        load_alu_prog();
        release_reset();
        #1;
        n_cmp++;
        if (bus.mem_rd !== 1'b0) begin
            n_bad++; $display("FAIL reset_first_cycle_rd: got %b want 0", bus.mem_rd);
        end
        k = 0;
        while (acc !== 8'h7F && k < 20) begin @(negedge clk); k++; end
        n_cmp++;
        if (acc !== 8'h7F) begin
            n_bad++; $display("FAIL reset_pre_lda: acc %h want 7f", acc);
        end
        ready_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 5'd1) begin
            n_bad++; $display("FAIL reset_stalled_fetch: rd %b addr %0d want 1/1", bus.mem_rd, bus.mem_addr);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0 || halt !== 1'b0) begin
            n_bad++; $display("FAIL reset_outputs: rd %b wr %b halt %b want 0/0/0", bus.mem_rd, bus.mem_wr, halt);
        end
        n_cmp++;
        if (acc !== 8'h00 || is_zero !== 1'b1 || bus.mem_addr !== 5'd0) begin
            n_bad++; $display("FAIL reset_regs: acc %h is_zero %b pc %0d want 00/1/0", acc, is_zero, bus.mem_addr);
        end
        ready_en = 1'b1;
    endtask

    task automatic test_alu();
        int cyc;
        wait_cfg = 0;
        hold_reset();
        load_alu_prog();
        release_reset();
        run_to_halt(cyc);
        n_cmp++;
        if (cyc !== 11) begin
            n_bad++; $display("FAIL alu_halt_cycle: got %0d want 11", cyc);
        end
        n_cmp++;
        if (acc !== 8'h02 || is_zero !== 1'b0 || mem[12] !== 8'h02) begin
            n_bad++; $display("FAIL alu_result: acc %h is_zero %b mem12 %h want 02/0/02", acc, is_zero, mem[12]);
        end
        n_cmp++;
        if (bus.mem_addr !== 5'd4 || bus.mem_rd !== 1'b0) begin
            n_bad++; $display("FAIL alu_halt_pc: pc %0d rd %b want 4/0", bus.mem_addr, bus.mem_rd);
        end
        n_cmp++;
        if (log_n !== 7) begin
            n_bad++; $display("FAIL alu_trace_len: got %0d want 7", log_n);
        end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (log_wr[i] !== exp_wr[i] || log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("FAIL alu_trace[%0d]: got wr%b @%0d %h want wr%b @%0d %h", i,
                         log_wr[i], log_addr[i], log_data[i], exp_wr[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_skz();
        int   cyc;
        logic seen [0:31];
        hold_reset();
        mem[0]  = 8'h20;  // SKZ   (acc=0: skip addr 1)
        mem[1]  = 8'hE5;  // JMP 5 (must not be fetched)
        mem[2]  = 8'h8A;  // XOR 10
        mem[3]  = 8'h20;  // SKZ   (acc=1: no skip)
        mem[4]  = 8'hE8;  // JMP 8
        mem[5]  = 8'hCC;  // STO 12 (must not run)
        mem[8]  = 8'h00;  // HLT
        mem[10] = 8'h01;
        release_reset();
        run_to_halt(cyc);
        for (int i = 0; i < 32; i++) seen[i] = 1'b0;
        for (int i = 0; i < log_n; i++) if (!log_wr[i]) seen[log_addr[i]] = 1'b1;
        n_cmp++;
        if (seen[1] !== 1'b0 || seen[2] !== 1'b1) begin
            n_bad++; $display("FAIL skz_taken: fetched1 %b fetched2 %b want 0/1", seen[1], seen[2]);
        end
        n_cmp++;
        if (seen[4] !== 1'b1 || seen[5] !== 1'b0 || seen[8] !== 1'b1) begin
            n_bad++; $display("FAIL skz_not_taken_jmp: f4 %b f5 %b f8 %b want 1/0/1", seen[4], seen[5], seen[8]);
        end
        n_cmp++;
        if (acc !== 8'h01 || halt !== 1'b1 || mem[12] !== 8'h00) begin
            n_bad++; $display("FAIL skz_state: acc %h halt %b mem12 %h want 01/1/00", acc, halt, mem[12]);
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        wait_cfg = 3;
        hold_reset();
        load_alu_prog();
        release_reset();
        run_to_halt(cyc);
        n_cmp++;
        if (cyc !== 23) begin
            n_bad++; $display("FAIL wait_halt_cycle: got %0d want 23", cyc);
        end
        n_cmp++;
        if (stab_err !== 0) begin
            n_bad++; $display("FAIL wait_bus_stable: got %0d changes want 0", stab_err);
        end
        n_cmp++;
        if (log_n !== 7 || acc !== 8'h02) begin
            n_bad++; $display("FAIL wait_trace_len: len %0d acc %h want 7/02", log_n, acc);
        end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (log_wr[i] !== exp_wr[i] || log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                n_bad++;
                $display("FAIL wait_trace[%0d]: got wr%b @%0d %h want wr%b @%0d %h", i,
                         log_wr[i], log_addr[i], log_data[i], exp_wr[i], exp_addr[i], exp_data[i]);
            end
        end
        wait_cfg = 0;
    endtask

    task automatic test_wrap_resume();
        int cyc;
        int n_before;
        hold_reset();
        mem[0]  = 8'hFF;  // JMP 31
        mem[31] = 8'h00;  // HLT
        release_reset();
        run_to_halt(cyc);
        n_cmp++;
        if (halt !== 1'b1 || bus.mem_addr !== 5'd0) begin
            n_bad++; $display("FAIL wrap_pc: halt %b pc %0d want 1/0", halt, bus.mem_addr);
        end
        n_before = log_n;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (halt !== 1'b1 || log_n !== n_before || bus.mem_rd !== 1'b0) begin
            n_bad++; $display("FAIL halt_hold: halt %b accesses %0d rd %b want 1/0/0", halt, log_n - n_before, bus.mem_rd);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        n_cmp++;
        if (halt !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 5'd0) begin
            n_bad++; $display("FAIL resume_fetch: halt %b rd %b addr %0d want 0/1/0", halt, bus.mem_rd, bus.mem_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 5'd31) begin
            n_bad++; $display("FAIL resume_jmp: rd %b addr %0d want 1/31", bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_params();
        int k;
        hold_reset();
        for (int i = 0; i < 16; i++) mem2[i] = 16'h0000;
        mem2[0] = 16'hA008;  // LDA 8
        mem2[1] = 16'h4009;  // ADD 9
        mem2[2] = 16'h0000;  // HLT
        mem2[8] = 16'hFFFF;
        mem2[9] = 16'h0002;
        release_reset();
        k = 0;
        while (!halt2 && k < 50) begin @(negedge clk); k++; end
        n_cmp++;
        if (halt2 !== 1'b1 || acc2 !== 16'h0001 || is_zero2 !== 1'b0) begin
            n_bad++; $display("FAIL wide_add: halt %b acc %h is_zero %b want 1/0001/0", halt2, acc2, is_zero2);
        end
        n_cmp++;
        if (bus2.mem_addr !== 10'd3) begin
            n_bad++; $display("FAIL wide_pc: got %0d want 3", bus2.mem_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) mem2[i] = 16'h0000;
        test_reset();
        test_alu();
        test_skz();
        test_wait_states();
        test_wrap_resume();
        test_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
